// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU datapath (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Big-endian byte-addressed data memory with a valid/ready request port and a
// one-cycle response strobe after WAIT_CYCLES wait states.
// Optional feature macro: ALIGN_CHECK_EN (misaligned word accesses flag resp_err
// and are not performed).
module data_mem_responder #(
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_req_ready;
   logic                r_resp_valid;
   logic [31:0]         r_resp_rdata;
   logic                r_resp_err;
   logic [7:0]          r_mem [DEPTH];

   logic                w_accept;
   logic                w_cmd_we;
   logic [ADDR_W-1:0]   w_cmd_addr;
   logic [31:0]         w_cmd_wdata;
   logic [ADDR_W-1:0]   w_baddr [4];
   logic                w_misaligned;
   logic                w_commit;
   logic                w_wr_en;
   logic [31:0]         w_rd_word;

   assign w_accept = bus.req_valid & (r_state == ST_IDLE);

   // With zero wait states the commit happens on the accept edge, so use the live request there.
   assign w_cmd_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
   assign w_cmd_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
   assign w_cmd_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

   // Byte lanes a..a+3 wrap modulo DEPTH.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_baddr[k] = w_cmd_addr + ADDR_W'(k);
      end
   end

`ifdef ALIGN_CHECK_EN
   assign w_misaligned = (w_cmd_addr[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_rd_word = {r_mem[w_baddr[0]], r_mem[w_baddr[1]], r_mem[w_baddr[2]], r_mem[w_baddr[3]]};
   assign w_commit  = ~reset & (w_next_state == ST_RESP);
   assign w_wr_en   = w_commit & w_cmd_we & ~w_misaligned;

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State, request latch, wait counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_req_ready  <= (w_next_state == ST_IDLE);
         r_resp_valid <= (w_next_state == ST_RESP);
         if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_commit) begin
            r_resp_rdata <= (w_cmd_we | w_misaligned) ? 32'h0 : w_rd_word;
            r_resp_err   <= w_misaligned;
         end
      end
   end

   // Byte array write on the edge entering RESP; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_baddr[0]] <= w_cmd_wdata[31:24];
         r_mem[w_baddr[1]] <= w_cmd_wdata[23:16];
         r_mem[w_baddr[2]] <= w_cmd_wdata[15:8];
         r_mem[w_baddr[3]] <= w_cmd_wdata[7:0];
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned W      = 2;
   localparam int unsigned TMO    = 40;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_mem_responder_if #(.ADDR_W(ADDR_W)) bus  ();
   data_mem_responder_if #(.ADDR_W(ADDR_W)) bus0 ();

   data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] ref_mem [DEPTH];

   function automatic logic [31:0] ref_word(input int a);
      return {ref_mem[a % DEPTH], ref_mem[(a + 1) % DEPTH],
              ref_mem[(a + 2) % DEPTH], ref_mem[(a + 3) % DEPTH]};
   endfunction

   function automatic bit ref_misaligned(input int a);
`ifdef ALIGN_CHECK_EN
      return (a % 4) != 0;
`else
      return (a < 0);
`endif
   endfunction

   // One full request: accept, scramble inputs while busy, check latency and response.
   task automatic txn(input bit we, input int a, input logic [31:0] wd, input string nm,
                      output logic [31:0] rd);
      bit          mis;
      logic [31:0] exp_rd;
      int          lat;
      int          busy_ready;
      mis    = ref_misaligned(a);
      exp_rd = (we || mis) ? 32'h0 : ref_word(a);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL %s ready_idle: got %b want 1", nm, bus.req_ready);
      end
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = ADDR_W'(a);
      bus.req_wdata = wd;
      @(posedge clk); #1;
      lat = 0;
      busy_ready = 0;
      while (bus.resp_valid !== 1'b1 && lat < TMO) begin
         if (bus.req_ready !== 1'b0) busy_ready++;
         bus.req_valid = 1'($urandom);
         bus.req_we    = 1'($urandom);
         bus.req_addr  = ADDR_W'($urandom);
         bus.req_wdata = $urandom;
         @(posedge clk); #1;
         lat++;
      end
      rd = bus.resp_rdata;
      bus.req_valid = 1'b0;
      checks++;
      if (lat != W) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, W);
      end
      checks++;
      if (busy_ready != 0 || bus.req_ready !== 1'b0) begin
         errors++; $display("FAIL %s ready_busy: got %0d high cycles want 0", nm, busy_ready);
      end
      checks++;
      if (bus.resp_rdata !== exp_rd) begin
         errors++; $display("FAIL %s rdata: got %h want %h", nm, bus.resp_rdata, exp_rd);
      end
      checks++;
      if (bus.resp_err !== mis) begin
         errors++; $display("FAIL %s err: got %b want %b", nm, bus.resp_err, mis);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== exp_rd) begin
         errors++; $display("FAIL %s after_resp: got valid=%b ready=%b rdata=%h want 0 1 %h",
                            nm, bus.resp_valid, bus.req_ready, bus.resp_rdata, exp_rd);
      end
      if (we && !mis) begin
         for (int k = 0; k < 4; k++) ref_mem[(a + k) % DEPTH] = wd[31 - 8*k -: 8];
      end
   endtask

   task automatic test_reset();
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr   = '0;
      bus.req_wdata  = 32'hA5A5A5A5;
      bus0.req_valid = 1'b0;
      bus0.req_we    = 1'b0;
      bus0.req_addr  = '0;
      bus0.req_wdata = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
          bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
         errors++; $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                            bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.req_valid = 1'b0;
      for (int i = 0; i < int'(W) + 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_no_accept: got valid=%b ready=%b want 0 1",
                               bus.resp_valid, bus.req_ready);
         end
      end
   endtask

   task automatic test_prefill();
      logic [31:0] rd;
      for (int a = 0; a < int'(DEPTH); a += 4) txn(1'b1, a, $urandom, "prefill", rd);
   endtask

   task automatic test_basic();
      logic [31:0] rd;
      txn(1'b1, 8, 32'hDEADBEEF, "basic_wr", rd);
      txn(1'b0, 8, 32'h0, "basic_rd", rd);
      checks++;
      if (rd[31:24] !== 8'hDE || rd[7:0] !== 8'hEF) begin
         errors++; $display("FAIL basic_bytes: got %h want DExxxxEF", rd);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd;
      txn(1'b1, 8'h3C, 32'h11223344, "wrap_wr", rd);
      txn(1'b0, 8'h3C, 32'h0, "wrap_rd", rd);
      checks++;
      if (rd !== 32'h11223344) begin
         errors++; $display("FAIL wrap_word: got %h want 11223344", rd);
      end
`ifndef ALIGN_CHECK_EN
      txn(1'b0, 8'h3E, 32'h0, "wrap_3e", rd);
      checks++;
      if (rd[31:16] !== 16'h3344) begin
         errors++; $display("FAIL wrap_3e_hi: got %h want 3344", rd[31:16]);
      end
      txn(1'b1, 8'h3F, 32'hCAFEF00D, "wrap_wr3f", rd);
      txn(1'b0, 8'h00, 32'h0, "wrap_rd00", rd);
`endif
   endtask

`ifdef ALIGN_CHECK_EN
   task automatic test_misaligned();
      logic [31:0] rd;
      logic [31:0] old;
      old = ref_word(4);
      txn(1'b1, 5, 32'hFFFFFFFF, "mis_wr", rd);
      txn(1'b0, 4, 32'h0, "mis_rd", rd);
      checks++;
      if (rd !== old) begin
         errors++; $display("FAIL mis_unchanged: got %h want %h", rd, old);
      end
   endtask
`endif

   // Reset during WAIT; delay=1 lands the reset on the commit edge.
   task automatic test_reset_mid(input int delay);
      logic [31:0] rd;
      logic [31:0] old;
      old = ref_word(16);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = ADDR_W'(16);
      bus.req_wdata = ~old;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (delay) begin @(posedge clk); #1; end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid%0d_state: got valid=%b ready=%b want 0 1",
                            delay, bus.resp_valid, bus.req_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid%0d_no_resp: got valid=%b want 0", delay, bus.resp_valid);
         end
      end
      txn(1'b0, 16, 32'h0, "rstmid_rd", rd);
      checks++;
      if (rd !== old) begin
         errors++; $display("FAIL rstmid%0d_old: got %h want %h", delay, rd, old);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus0.req_valid = 1'b1;
      bus0.req_we    = 1'b1;
      bus0.req_addr  = '0;
      bus0.req_wdata = 32'h01020304;
      @(posedge clk); #1;
      checks++;
      if (bus0.resp_valid !== 1'b1 || bus0.resp_err !== 1'b0) begin
         errors++; $display("FAIL w0_wr_resp: got valid=%b err=%b want 1 0", bus0.resp_valid, bus0.resp_err);
      end
      bus0.req_valid = 1'b0;
      @(posedge clk); #1;
      bus0.req_valid = 1'b1;
      bus0.req_we    = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'h01020304 || bus0.req_ready !== 1'b0) begin
         errors++; $display("FAIL w0_rd1: got valid=%b rdata=%h ready=%b want 1 01020304 0",
                            bus0.resp_valid, bus0.resp_rdata, bus0.req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bus0.resp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
         errors++; $display("FAIL w0_gap: got valid=%b ready=%b want 0 1", bus0.resp_valid, bus0.req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'h01020304) begin
         errors++; $display("FAIL w0_rd2: got valid=%b rdata=%h want 1 01020304",
                            bus0.resp_valid, bus0.resp_rdata);
      end
      bus0.req_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus0.resp_valid !== 1'b0) begin
         errors++; $display("FAIL w0_end: got valid=%b want 0", bus0.resp_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd;
      for (int i = 0; i < 60; i++) begin
         txn(1'($urandom), int'($urandom_range(DEPTH - 1, 0)), $urandom, "random", rd);
      end
   endtask

   initial begin
      test_reset();
      test_prefill();
      test_basic();
      test_wrap();
`ifdef ALIGN_CHECK_EN
      test_misaligned();
`endif
      test_reset_mid(0);
      test_reset_mid(1);
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
